// File: rtl/psubs_seq_16bit_if.sv
// Start/done handshake bundle for the sequential packed saturating subtractor.
interface psubs_seq_16bit_if;
  logic        start;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        busy;
  logic        done;
  logic [15:0] diff_out;
  logic [3:0]  sat_lanes;

  modport master (
    output start, a_in, b_in,
    input  busy, done, diff_out, sat_lanes
  );

  modport slave (
    input  start, a_in, b_in,
    output busy, done, diff_out, sat_lanes
  );
endinterface

// File: rtl/psubs_seq_16bit.sv
// Packed 4x4-bit signed saturating subtractor, one lane per cycle (a + ~b + 1).
// Optional per-lane overflow flags: define PSUB_LANE_FLAGS_EN.
module psubs_seq_16bit #(
  parameter bit          SAT_EN = 1'b1,
  parameter int unsigned LANE_W = 4
) (
  input logic              clk,
  input logic              rst_n,
  psubs_seq_16bit_if.slave bus
);

  localparam int unsigned LANES = 16 / LANE_W;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state_q;
  logic [1:0]        cnt_q;
  logic [15:0]       a_q;
  logic [15:0]       b_q;
  logic [15:0]       diff_q;

  logic [LANE_W-1:0] a_lane;
  logic [LANE_W-1:0] b_lane;
  logic [LANE_W-1:0] d_raw;
  logic [LANE_W-1:0] lane_d;
  logic              ovf;

  always_comb begin
    a_lane = a_q[cnt_q*LANE_W +: LANE_W];
    b_lane = b_q[cnt_q*LANE_W +: LANE_W];
    d_raw  = a_lane + ~b_lane + LANE_W'(1);
    ovf    = (a_lane[LANE_W-1] != b_lane[LANE_W-1]) &&
             (d_raw[LANE_W-1]  != a_lane[LANE_W-1]);
    lane_d = d_raw;
    if (SAT_EN && ovf) begin
      lane_d = a_lane[LANE_W-1] ? {1'b1, {(LANE_W-1){1'b0}}}
                                : {1'b0, {(LANE_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a_in;
            b_q     <= bus.b_in;
            cnt_q   <= '0;
            state_q <= CALC;
          end
        end
        CALC: begin
          diff_q[cnt_q*LANE_W +: LANE_W] <= lane_d;
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == 2'(LANES - 1)) state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef PSUB_LANE_FLAGS_EN
  logic [3:0] sat_q;

  // Flags track raw overflow, so they report even when SAT_EN lets lanes wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_q <= '0;
    end else if (state_q == IDLE && bus.start) begin
      sat_q <= '0;
    end else if (state_q == CALC && ovf) begin
      sat_q[cnt_q] <= 1'b1;
    end
  end

  assign bus.sat_lanes = sat_q;
`else
  assign bus.sat_lanes = '0;
`endif

  assign bus.busy     = (state_q == CALC);
  assign bus.done     = (state_q == DONE);
  assign bus.diff_out = diff_q;

endmodule

// File: tb/tb_psubs_seq_16bit.sv
// Directed + random bench for psubs_seq_16bit with a queue-based result scoreboard.
module tb_psubs_seq_16bit;

  localparam bit TB_SAT_EN = 1'b1;
`ifdef PSUB_LANE_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  typedef struct {
    string       tag;
    logic [15:0] d;
    logic [3:0]  s;
  } exp_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  exp_t sb[$];

  psubs_seq_16bit_if bus ();

  psubs_seq_16bit #(.SAT_EN(TB_SAT_EN), .LANE_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: signed integer difference clamped to [-8,7] or wrapped mod 16.
  function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] d;
    logic [3:0]  s;
    int sa, sbv, r;
    d = '0;
    s = '0;
    for (int k = 0; k < 4; k++) begin
      sa  = int'(a[k*4 +: 4]);
      sbv = int'(b[k*4 +: 4]);
      if (sa > 7) sa -= 16;
      if (sbv > 7) sbv -= 16;
      r = sa - sbv;
      if (r > 7 || r < -8) begin
        s[k] = 1'b1;
        if (TB_SAT_EN) r = (r > 7) ? 7 : -8;
      end
      d[k*4 +: 4] = 4'(r & 15);
    end
    return {s, d};
  endfunction

  task automatic issue(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] ed, input logic [3:0] es);
    exp_t e;
    e.tag = tag;
    e.d   = ed;
    e.s   = FLAGS ? es : 4'b0000;
    sb.push_back(e);
    bus.a_in  = a;
    bus.b_in  = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(posedge clk);
      n++;
    end
    #1 check({tag, "_pending"}, 16'(sb.size()), 16'h0);
  endtask

  // Result monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("busy_and_done", {15'h0, bus.busy & bus.done}, 16'h0);
      if (bus.done === 1'b1) begin
        if (sb.size() == 0) begin
          check("spurious_done", 16'h1, 16'h0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check({e.tag, "_diff"}, bus.diff_out, e.d);
          check({e.tag, "_sat"}, {12'h0, bus.sat_lanes}, {12'h0, e.s});
        end
      end
    end
  end

  initial begin
    logic [15:0] ra, rb;
    logic [19:0] m;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {15'h0, bus.busy}, 16'h0);
    check("rst_done", {15'h0, bus.done}, 16'h0);
    check("rst_diff", bus.diff_out, 16'h0000);
    check("rst_sat", {12'h0, bus.sat_lanes}, 16'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: basic op with cycle-exact busy/done timing
    issue("t1", 16'h1234, 16'h1111, 16'h0123, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t1_busy", {15'h0, bus.busy}, 16'h1);
      check("t1_nodone", {15'h0, bus.done}, 16'h0);
    end
    @(negedge clk);
    check("t1_done", {15'h0, bus.done}, 16'h1);
    check("t1_busy_off", {15'h0, bus.busy}, 16'h0);
    drain("t1");

    // 2-4: saturation patterns and lane boundaries
    issue("t2", 16'h7070, 16'h8181, 16'h7F7F, 4'b1010);
    drain("t2");
    issue("t3", 16'h8888, 16'h1111, TB_SAT_EN ? 16'h8888 : 16'h7777, 4'b1111);
    drain("t3");
    issue("t4", 16'h8070, 16'h8188, 16'h0F77, 4'b0011);
    drain("t4");

    // 5: start and operand changes during CALC are ignored; result holds after done
    issue("t5", 16'h1234, 16'h1111, 16'h0123, 4'b0000);
    @(negedge clk);
    bus.a_in  = 16'hFFFF;
    bus.b_in  = 16'h0001;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    drain("t5");
    repeat (3) begin
      @(negedge clk);
      check("t5_hold", bus.diff_out, 16'h0123);
      check("t5_idle_done", {15'h0, bus.done}, 16'h0);
    end

    // 6: reset during the second CALC cycle discards the operation
    issue("t6", 16'h7070, 16'h8181, 16'h7F7F, 4'b1010);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    sb.delete();
    check("t6_busy", {15'h0, bus.busy}, 16'h0);
    check("t6_done", {15'h0, bus.done}, 16'h0);
    check("t6_diff", bus.diff_out, 16'h0000);
    check("t6_sat", {12'h0, bus.sat_lanes}, 16'h0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    issue("t6_after", 16'h8070, 16'h8188, 16'h0F77, 4'b0011);
    drain("t6_after");

    // random operands against the integer model
    for (int i = 0; i < 6; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      m  = model(ra, rb);
      issue("rnd", ra, rb, m[15:0], m[19:16]);
      drain("rnd");
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
